matrix_mac_engine: RTL and testbench



---
 rtl/matrix_mac_engine_if.sv | 22 ++
 rtl/matrix_mac_engine.sv | 286 ++++++++++++++++++++++++++++
 tb/tb_matrix_mac_engine.sv | 307 ++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/matrix_mac_engine_if.sv
// Command/result bundle between the coprocessor decoder and matrix_mac_engine.
interface matrix_mac_engine_if #(
  parameter int unsigned DIM = 2
);
  logic                    start;
  logic                    accumulate;
  logic [DIM*DIM*32-1:0]   matrix_a;
  logic [DIM*DIM*32-1:0]   matrix_b;
  logic                    busy;
  logic                    done;
  logic [DIM*DIM*32-1:0]   result;

  modport master (
    output start, accumulate, matrix_a, matrix_b,
    input  busy, done, result
  );

  modport slave (
    input  start, accumulate, matrix_a, matrix_b,
    output busy, done, result
  );
endinterface

// File: rtl/matrix_mac_engine.sv
// DIM x DIM single-precision C = A*B / C += A*B engine time-sharing one FP multiplier (unit 0)
// and one FP adder (unit 1), both stb/ack units modelled in-module, under a sequencing FSM.
module matrix_mac_engine #(
  parameter int unsigned DIM = 2
) (
  input logic                clock,
  input logic                reset,
  matrix_mac_engine_if.slave bus_io
);
  localparam int unsigned W      = DIM * DIM * 32;
  localparam int unsigned MulLat = 3;
  localparam int unsigned AddLat = 4;
  localparam logic [1:0]  Last   = 2'(DIM - 1);

  typedef enum logic [2:0] {
    StIdle, StMulIssue, StMulWait, StAddIssue, StAddWait, StWrite, StDone
  } state_e;

  // Round-to-nearest-even; denormal inputs and results flush to signed zero.
  function automatic logic [31:0] fp_mul(input logic [31:0] a, input logic [31:0] b);
    logic        s;
    logic [47:0] p;
    logic [22:0] m;
    logic        g, st;
    logic [24:0] r;
    int          e;
    s = a[31] ^ b[31];
    if ((a[30:23] == 8'hFF && a[22:0] != '0) || (b[30:23] == 8'hFF && b[22:0] != '0))
      return 32'h7FC0_0000;
    if (a[30:23] == 8'hFF || b[30:23] == 8'hFF)
      return (a[30:0] == '0 || b[30:0] == '0) ? 32'h7FC0_0000 : {s, 8'hFF, 23'h0};
    if (a[30:23] == 8'h00 || b[30:23] == 8'h00) return {s, 31'h0};
    p = 48'({1'b1, a[22:0]}) * 48'({1'b1, b[22:0]});
    e = int'(a[30:23]) + int'(b[30:23]) - 127;
    if (p[47]) begin
      m = p[46:24]; g = p[23]; st = |p[22:0]; e = e + 1;
    end else begin
      m = p[45:23]; g = p[22]; st = |p[21:0];
    end
    r = {2'b01, m} + {24'd0, g & (st | m[0])};
    if (r[24]) e = e + 1;
    if (e >= 255) return {s, 8'hFF, 23'h0};
    if (e <= 0) return {s, 31'h0};
    return {s, e[7:0], r[24] ? r[23:1] : r[22:0]};
  endfunction

  function automatic logic [31:0] fp_add(input logic [31:0] x_in, input logic [31:0] y_in);
    logic [31:0] a, b;
    logic [27:0] m, n;
    logic [24:0] r;
    logic        lost;
    int          e, d;
    if ((x_in[30:23] == 8'hFF && x_in[22:0] != '0) || (y_in[30:23] == 8'hFF && y_in[22:0] != '0))
      return 32'h7FC0_0000;
    if (x_in[30:23] == 8'hFF)
      return (y_in[30:23] == 8'hFF && x_in[31] != y_in[31]) ? 32'h7FC0_0000 : x_in;
    if (y_in[30:23] == 8'hFF) return y_in;
    if (x_in[30:23] == 8'h00) return (y_in[30:23] == 8'h00) ? {x_in[31] & y_in[31], 31'h0} : y_in;
    if (y_in[30:23] == 8'h00) return x_in;
    if (x_in[30:0] >= y_in[30:0]) begin
      a = x_in; b = y_in;
    end else begin
      a = y_in; b = x_in;
    end
    e = int'(a[30:23]);
    d = e - int'(b[30:23]);
    m = {2'b01, a[22:0], 3'b000};
    n = {2'b01, b[22:0], 3'b000};
    // Bits shifted out of the smaller operand collapse into the sticky bit.
    if (d > 26) begin
      n = 28'd1;
    end else begin
      lost = (n & ((28'd1 << d) - 28'd1)) != '0;
      n = (n >> d) | {27'd0, lost};
    end
    m = (a[31] == b[31]) ? m + n : m - n;
    if (m == '0) return 32'h0;
    if (m[27]) begin
      m = {1'b0, m[27:2], m[1] | m[0]};
      e = e + 1;
    end
    for (int s = 0; s < 26; s++) begin
      if (!m[26]) begin
        m = m << 1;
        e = e - 1;
      end
    end
    r = {1'b0, m[26:3]} + {24'd0, m[2] & (m[3] | m[1] | m[0])};
    if (r[24]) e = e + 1;
    if (e >= 255) return {a[31], 8'hFF, 23'h0};
    if (e <= 0) return {a[31], 31'h0};
    return {a[31], e[7:0], r[24] ? r[23:1] : r[22:0]};
  endfunction

  // FP unit handshake signals, index 0 = multiplier, 1 = adder.
  logic [1:0]       fp_a_stb, fp_b_stb, fp_a_ack, fp_b_ack, fp_z_stb, fp_z_ack;
  logic [1:0][31:0] fp_a, fp_b, fp_z, fp_res;
  logic [1:0]       have_a_q, have_b_q, z_stb_q, unit_run;
  logic [1:0][31:0] op_a_q, op_b_q, z_q;
  logic [1:0][2:0]  cnt_q;

  always_comb begin
    fp_res[0] = fp_mul(op_a_q[0], op_b_q[0]);
    fp_res[1] = fp_add(op_a_q[1], op_b_q[1]);
    for (int u = 0; u < 2; u++) begin
      unit_run[u] = (cnt_q[u] != 3'd0) | z_stb_q[u];
      fp_a_ack[u] = fp_a_stb[u] & ~have_a_q[u] & ~unit_run[u];
      fp_b_ack[u] = fp_b_stb[u] & ~have_b_q[u] & ~unit_run[u];
    end
  end

  assign fp_z_stb = z_stb_q;
  assign fp_z     = z_q;

  always_ff @(posedge clock) begin
    if (reset) begin
      have_a_q <= '0;
      have_b_q <= '0;
      z_stb_q  <= '0;
      cnt_q    <= '0;
      op_a_q   <= '0;
      op_b_q   <= '0;
      z_q      <= '0;
    end else begin
      for (int u = 0; u < 2; u++) begin
        if (fp_a_ack[u]) begin
          have_a_q[u] <= 1'b1;
          op_a_q[u]   <= fp_a[u];
        end
        if (fp_b_ack[u]) begin
          have_b_q[u] <= 1'b1;
          op_b_q[u]   <= fp_b[u];
        end
        if (have_a_q[u] && have_b_q[u] && !unit_run[u]) begin
          have_a_q[u] <= 1'b0;
          have_b_q[u] <= 1'b0;
          cnt_q[u]    <= (u == 0) ? 3'(MulLat) : 3'(AddLat);
        end else if (cnt_q[u] == 3'd1) begin
          cnt_q[u]   <= 3'd0;
          z_q[u]     <= fp_res[u];
          z_stb_q[u] <= 1'b1;
        end else if (cnt_q[u] != 3'd0) begin
          cnt_q[u] <= cnt_q[u] - 3'd1;
        end
        if (z_stb_q[u] && fp_z_ack[u]) z_stb_q[u] <= 1'b0;
      end
    end
  end

  state_e         state_q, state_d;
  logic [1:0]     i_q, i_d, j_q, j_d, k_q, k_d;
  logic [W-1:0]   a_q, a_d, b_q, b_d, result_q, result_d;
  logic           mode_q, mode_d, a_got_q, a_got_d, b_got_q, b_got_d;
  logic [31:0]    acc_q, acc_d, prod_q, prod_d;
  int unsigned    eik, ekj, eij;

  assign fp_a_stb = {state_q == StAddIssue && !a_got_q, state_q == StMulIssue && !a_got_q};
  assign fp_b_stb = {state_q == StAddIssue && !b_got_q, state_q == StMulIssue && !b_got_q};

  always_comb begin
    eik     = 32'(i_q) * DIM + 32'(k_q);
    ekj     = 32'(k_q) * DIM + 32'(j_q);
    eij     = 32'(i_q) * DIM + 32'(j_q);
    fp_a[0] = a_q[eik*32 +: 32];
    fp_b[0] = b_q[ekj*32 +: 32];
    // Accumulate mode seeds the sum with the previous C element on the first add.
    fp_a[1] = (mode_q && k_q == 2'd0) ? result_q[eij*32 +: 32] : acc_q;
    fp_b[1] = prod_q;
  end

  always_comb begin
    state_d  = state_q;
    i_d      = i_q;
    j_d      = j_q;
    k_d      = k_q;
    a_d      = a_q;
    b_d      = b_q;
    mode_d   = mode_q;
    acc_d    = acc_q;
    prod_d   = prod_q;
    result_d = result_q;
    a_got_d  = a_got_q;
    b_got_d  = b_got_q;
    fp_z_ack = '0;
    case (state_q)
      StIdle: begin
        if (bus_io.start) begin
          a_d     = bus_io.matrix_a;
          b_d     = bus_io.matrix_b;
          mode_d  = bus_io.accumulate;
          i_d     = '0;
          j_d     = '0;
          k_d     = '0;
          state_d = StMulIssue;
        end
      end
      StMulIssue, StAddIssue: begin
        a_got_d = a_got_q | (state_q == StMulIssue ? fp_a_ack[0] : fp_a_ack[1]);
        b_got_d = b_got_q | (state_q == StMulIssue ? fp_b_ack[0] : fp_b_ack[1]);
        if (a_got_d && b_got_d) begin
          a_got_d = 1'b0;
          b_got_d = 1'b0;
          state_d = (state_q == StMulIssue) ? StMulWait : StAddWait;
        end
      end
      StMulWait: begin
        if (fp_z_stb[0]) begin
          fp_z_ack[0] = 1'b1;
          if (!mode_q && k_q == 2'd0) begin
            acc_d = fp_z[0];
            if (k_q == Last) begin
              state_d = StWrite;
            end else begin
              k_d     = k_q + 2'd1;
              state_d = StMulIssue;
            end
          end else begin
            prod_d  = fp_z[0];
            state_d = StAddIssue;
          end
        end
      end
      StAddWait: begin
        if (fp_z_stb[1]) begin
          fp_z_ack[1] = 1'b1;
          acc_d       = fp_z[1];
          if (k_q == Last) begin
            state_d = StWrite;
          end else begin
            k_d     = k_q + 2'd1;
            state_d = StMulIssue;
          end
        end
      end
      StWrite: begin
        result_d[eij*32 +: 32] = acc_q;
        k_d     = '0;
        state_d = StMulIssue;
        if (j_q == Last) begin
          j_d = '0;
          if (i_q == Last) state_d = StDone;
          else             i_d = i_q + 2'd1;
        end else begin
          j_d = j_q + 2'd1;
        end
      end
      StDone:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q  <= StIdle;
      i_q      <= '0;
      j_q      <= '0;
      k_q      <= '0;
      a_q      <= '0;
      b_q      <= '0;
      mode_q   <= 1'b0;
      acc_q    <= '0;
      prod_q   <= '0;
      result_q <= '0;
      a_got_q  <= 1'b0;
      b_got_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      i_q      <= i_d;
      j_q      <= j_d;
      k_q      <= k_d;
      a_q      <= a_d;
      b_q      <= b_d;
      mode_q   <= mode_d;
      acc_q    <= acc_d;
      prod_q   <= prod_d;
      result_q <= result_d;
      a_got_q  <= a_got_d;
      b_got_q  <= b_got_d;
    end
  end

  assign bus_io.busy   = (state_q != StIdle) && (state_q != StDone);
  assign bus_io.done   = (state_q == StDone);
  assign bus_io.result = result_q;

endmodule

// File: tb/tb_matrix_mac_engine.sv
// Scoreboard bench for matrix_mac_engine: a DIM=2 instance for most scenarios, DIM=3 for the
// handshake-count check.
module tb_matrix_mac_engine;
  localparam int unsigned W2 = 2 * 2 * 32;
  localparam int unsigned W3 = 3 * 3 * 32;

  logic clock = 1'b0;
  logic reset = 1'b1;
  int   n_cmp = 0;
  int   n_err = 0;
  int   done2_cnt = 0;
  int   mul3_cnt = 0;
  int   add3_cnt = 0;

  logic [W2-1:0] exp_q2[$];
  logic [W3-1:0] exp_q3[$];

  always #5 clock = ~clock;

  matrix_mac_engine_if #(.DIM(2)) bus2();
  matrix_mac_engine_if #(.DIM(3)) bus3();

  matrix_mac_engine #(.DIM(2)) dut2 (.clock(clock), .reset(reset), .bus_io(bus2));
  matrix_mac_engine #(.DIM(3)) dut3 (.clock(clock), .reset(reset), .bus_io(bus3));

  always @(negedge clock) begin
    if (bus2.done === 1'b1) done2_cnt++;
    if (dut3.fp_z_stb[0] && dut3.fp_z_ack[0]) mul3_cnt++;
    if (dut3.fp_z_stb[1] && dut3.fp_z_ack[1]) add3_cnt++;
  end

  function automatic logic [W2-1:0] pack2(input logic [31:0] e0, input logic [31:0] e1,
                                          input logic [31:0] e2, input logic [31:0] e3);
    return {e3, e2, e1, e0};
  endfunction

  logic [W2-1:0] mat_a, mat_i, mat_aa, mat_2a;

  task automatic pulse_start2(input logic acc, input logic [W2-1:0] a, input logic [W2-1:0] b);
    bus2.start      = 1'b1;
    bus2.accumulate = acc;
    bus2.matrix_a   = a;
    bus2.matrix_b   = b;
    @(negedge clock);
    bus2.start = 1'b0;
  endtask

  task automatic wait_done2(output bit seen);
    seen = 1'b0;
    for (int c = 0; c < 2000; c++) begin
      if (bus2.done === 1'b1) begin
        seen = 1'b1;
        break;
      end
      @(negedge clock);
    end
  endtask

  task automatic wait_done3(output bit seen);
    seen = 1'b0;
    for (int c = 0; c < 3000; c++) begin
      if (bus3.done === 1'b1) begin
        seen = 1'b1;
        break;
      end
      @(negedge clock);
    end
  endtask

  task automatic test_reset;
    reset = 1'b1;
    repeat (3) @(negedge clock);
    n_cmp++;
    if (bus2.busy !== 1'b0) begin
      n_err++; $display("FAIL reset_busy: got %b, expected 0", bus2.busy);
    end
    n_cmp++;
    if (bus2.done !== 1'b0) begin
      n_err++; $display("FAIL reset_done: got %b, expected 0", bus2.done);
    end
    n_cmp++;
    if (bus2.result !== '0) begin
      n_err++; $display("FAIL reset_result2: got %h, expected 0", bus2.result);
    end
    n_cmp++;
    if (bus3.result !== '0 || bus3.busy !== 1'b0) begin
      n_err++; $display("FAIL reset_dim3: got result %h busy %b, expected 0/0", bus3.result, bus3.busy);
    end
    n_cmp++;
    if ({dut2.fp_a_stb, dut2.fp_b_stb, dut2.fp_z_stb, dut2.fp_z_ack} !== 8'h00) begin
      n_err++; $display("FAIL reset_strobes: got %h, expected 00",
                        {dut2.fp_a_stb, dut2.fp_b_stb, dut2.fp_z_stb, dut2.fp_z_ack});
    end
    reset = 1'b0;
    @(negedge clock);
  endtask

  task automatic test_plain_identity;
    bit            seen;
    int            d0;
    logic [W2-1:0] expv;
    d0 = done2_cnt;
    exp_q2.push_back(mat_a);
    pulse_start2(1'b0, mat_a, mat_i);
    n_cmp++;
    if (bus2.busy !== 1'b1) begin
      n_err++; $display("FAIL busy_rise: got %b, expected 1", bus2.busy);
    end
    wait_done2(seen);
    if (!seen) begin
      n_cmp++; n_err++; $display("FAIL plain_identity_timeout: got no done, expected done");
    end else begin
      expv = exp_q2.pop_front();
      n_cmp++;
      if (bus2.result !== expv) begin
        n_err++; $display("FAIL plain_identity: got %h, expected %h", bus2.result, expv);
      end
      n_cmp++;
      if (bus2.busy !== 1'b0) begin
        n_err++; $display("FAIL busy_at_done: got %b, expected 0", bus2.busy);
      end
    end
    repeat (3) @(negedge clock);
    n_cmp++;
    if (done2_cnt - d0 !== 1 || bus2.busy !== 1'b0) begin
      n_err++; $display("FAIL single_done: got %0d dones busy %b, expected 1 done busy 0",
                        done2_cnt - d0, bus2.busy);
    end
  endtask

  task automatic test_plain_square;
    bit            seen;
    logic [W2-1:0] expv;
    exp_q2.push_back(mat_aa);
    pulse_start2(1'b0, mat_a, mat_a);
    wait_done2(seen);
    if (!seen) begin
      n_cmp++; n_err++; $display("FAIL plain_square_timeout: got no done, expected done");
    end else begin
      expv = exp_q2.pop_front();
      n_cmp++;
      if (bus2.result !== expv) begin
        n_err++; $display("FAIL plain_square: got %h, expected %h", bus2.result, expv);
      end
    end
    repeat (2) @(negedge clock);
  endtask

  task automatic test_accumulate;
    bit            seen;
    logic [W2-1:0] expv;
    for (int r = 0; r < 2; r++) begin
      exp_q2.push_back(r == 0 ? mat_a : mat_2a);
      pulse_start2(r == 1, mat_a, mat_i);
      wait_done2(seen);
      if (!seen) begin
        n_cmp++; n_err++; $display("FAIL accumulate_timeout_%0d: got no done, expected done", r);
      end else begin
        expv = exp_q2.pop_front();
        n_cmp++;
        if (bus2.result !== expv) begin
          n_err++; $display("FAIL accumulate_%0d: got %h, expected %h", r, bus2.result, expv);
        end
      end
      repeat (2) @(negedge clock);
    end
  endtask

  task automatic test_restart_ignored;
    bit            seen;
    int            d0;
    logic [W2-1:0] expv;
    d0 = done2_cnt;
    exp_q2.push_back(mat_aa);
    pulse_start2(1'b0, mat_a, mat_a);
    repeat (4) @(negedge clock);
    bus2.start    = 1'b1;
    bus2.matrix_a = mat_i;
    @(negedge clock);
    bus2.start = 1'b0;
    wait_done2(seen);
    if (!seen) begin
      n_cmp++; n_err++; $display("FAIL restart_timeout: got no done, expected done");
    end else begin
      expv = exp_q2.pop_front();
      n_cmp++;
      if (bus2.result !== expv) begin
        n_err++; $display("FAIL restart_captured: got %h, expected %h", bus2.result, expv);
      end
      bus2.start = 1'b1;
      @(negedge clock);
      bus2.start = 1'b0;
      n_cmp++;
      if (bus2.busy !== 1'b0) begin
        n_err++; $display("FAIL start_in_done_lost: got busy %b, expected 0", bus2.busy);
      end
    end
    repeat (200) @(negedge clock);
    n_cmp++;
    if (done2_cnt - d0 !== 1 || bus2.result !== mat_aa) begin
      n_err++; $display("FAIL restart_one_done: got %0d dones result %h, expected 1 and %h",
                        done2_cnt - d0, bus2.result, mat_aa);
    end
  endtask

  task automatic test_reset_midway;
    bit            seen;
    int            d0;
    logic [W2-1:0] expv;
    exp_q2.push_back(mat_aa);
    pulse_start2(1'b0, mat_a, mat_a);
    repeat (30) @(negedge clock);
    reset = 1'b1;
    @(negedge clock);
    reset = 1'b0;
    exp_q2.delete();
    d0 = done2_cnt;
    n_cmp++;
    if (bus2.result !== '0 || bus2.busy !== 1'b0) begin
      n_err++; $display("FAIL midway_reset: got result %h busy %b, expected 0/0",
                        bus2.result, bus2.busy);
    end
    repeat (200) @(negedge clock);
    n_cmp++;
    if (done2_cnt !== d0) begin
      n_err++; $display("FAIL midway_no_done: got %0d dones, expected 0", done2_cnt - d0);
    end
    exp_q2.push_back(mat_aa);
    pulse_start2(1'b0, mat_a, mat_a);
    wait_done2(seen);
    if (!seen) begin
      n_cmp++; n_err++; $display("FAIL after_reset_timeout: got no done, expected done");
    end else begin
      expv = exp_q2.pop_front();
      n_cmp++;
      if (bus2.result !== expv) begin
        n_err++; $display("FAIL after_reset: got %h, expected %h", bus2.result, expv);
      end
    end
    repeat (2) @(negedge clock);
  endtask

  task automatic test_dim3;
    bit            seen;
    int            m0, a0;
    logic [W3-1:0] a3, i3, expv;
    for (int r = 0; r < 3; r++) begin
      for (int c = 0; c < 3; c++) begin
        a3[(r*3+c)*32 +: 32] = (r == c) ? 32'h4000_0000 : 32'h0;
        i3[(r*3+c)*32 +: 32] = (r == c) ? 32'h3F80_0000 : 32'h0;
      end
    end
    m0 = mul3_cnt;
    a0 = add3_cnt;
    exp_q3.push_back(a3);
    bus3.start      = 1'b1;
    bus3.accumulate = 1'b0;
    bus3.matrix_a   = a3;
    bus3.matrix_b   = i3;
    @(negedge clock);
    bus3.start = 1'b0;
    wait_done3(seen);
    if (!seen) begin
      n_cmp++; n_err++; $display("FAIL dim3_timeout: got no done, expected done");
    end else begin
      expv = exp_q3.pop_front();
      n_cmp++;
      if (bus3.result !== expv) begin
        n_err++; $display("FAIL dim3_result: got %h, expected %h", bus3.result, expv);
      end
    end
    repeat (3) @(negedge clock);
    n_cmp++;
    if (mul3_cnt - m0 !== 27) begin
      n_err++; $display("FAIL dim3_mul_count: got %0d, expected 27", mul3_cnt - m0);
    end
    n_cmp++;
    if (add3_cnt - a0 !== 18) begin
      n_err++; $display("FAIL dim3_add_count: got %0d, expected 18", add3_cnt - a0);
    end
  endtask

  initial begin
    mat_a  = pack2(32'h3F80_0000, 32'h4000_0000, 32'h4040_0000, 32'h4080_0000);
    mat_i  = pack2(32'h3F80_0000, 32'h0000_0000, 32'h0000_0000, 32'h3F80_0000);
    mat_aa = pack2(32'h40E0_0000, 32'h4120_0000, 32'h4170_0000, 32'h41B0_0000);
    mat_2a = pack2(32'h4000_0000, 32'h4080_0000, 32'h40C0_0000, 32'h4100_0000);
    bus2.start      = 1'b0;
    bus2.accumulate = 1'b0;
    bus2.matrix_a   = '0;
    bus2.matrix_b   = '0;
    bus3.start      = 1'b0;
    bus3.accumulate = 1'b0;
    bus3.matrix_a   = '0;
    bus3.matrix_b   = '0;
    @(negedge clock);
    test_reset();
    test_plain_identity();
    test_plain_square();
    test_accumulate();
    test_restart_ignored();
    test_reset_midway();
    test_dim3();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
